// File: rtl/driver_timer.sv
// ---------------------------------------------------------------------------
// driver_timer
//   Memory-mapped timer/counter peripheral on the DLX data bus.
//
//   The counter is driven by a prescaler and can either free-run with
//   auto-reload, or stop after one compare match (one-shot). A compare match
//   sets a sticky MATCH flag, which can optionally drive an interrupt line.
//
//   Register map (word offset = address[4:2]):
//     0 CTRL     : bit0 EN, bit1 AUTO, bit2 IRQ_EN (only with TIMER_IRQ_EN)
//     1 PRESCALE : tick period is PRESCALE+1 cycles
//     2 COMPARE  : match value
//     3 COUNT    : current count; a write loads the counter
//     4 STATUS   : bit0 MATCH, write 1 to clear
//     5..7       : reserved, read 0, writes ignored
//
//   Optional feature macro: TIMER_IRQ_EN
//     defined   : CTRL bit2 is stored; irq is a registered MATCH & IRQ_EN
//     undefined : CTRL bit2 reads 0; irq is tied 0
//
//   Ports:
//     clk          system clock
//     reset_n      asynchronous active-low reset
//     chip_select  timer address window select
//     address      CPU data address (only [4:2] decoded)
//     write_enable CPU write strobe, qualified by chip_select
//     data_write   CPU write data (low WIDTH bits stored)
//     data_read    combinational read of the addressed register
//     irq          registered match interrupt
// ---------------------------------------------------------------------------
module driver_timer #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        chip_select,
   input  logic [31:0] address,
   input  logic        write_enable,
   input  logic [31:0] data_write,
   output logic [31:0] data_read,
   output logic        irq
);

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_PRE    = 3'd1;
   localparam logic [2:0] A_CMP    = 3'd2;
   localparam logic [2:0] A_COUNT  = 3'd3;
   localparam logic [2:0] A_STATUS = 3'd4;

   logic             r_en;
   logic             r_auto;
   logic [WIDTH-1:0] r_prescale;
   logic [WIDTH-1:0] r_compare;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_pre_cnt;
   logic             r_match;

   logic             w_wr;
   logic [2:0]       w_sel;
   logic             w_wr_ctrl;
   logic             w_wr_pre;
   logic             w_wr_cmp;
   logic             w_wr_count;
   logic             w_wr_status;
   logic [WIDTH-1:0] w_wdata;
   logic             w_tick;
   logic [WIDTH-1:0] w_count_inc;
   logic             w_hit;
   logic             w_irq_en_rd;
   logic             w_unused;

   assign w_wr        = chip_select & write_enable;
   assign w_sel       = address[4:2];
   assign w_wr_ctrl   = w_wr && (w_sel == A_CTRL);
   assign w_wr_pre    = w_wr && (w_sel == A_PRE);
   assign w_wr_cmp    = w_wr && (w_sel == A_CMP);
   assign w_wr_count  = w_wr && (w_sel == A_COUNT);
   assign w_wr_status = w_wr && (w_sel == A_STATUS);
   assign w_wdata     = data_write[WIDTH-1:0];

   // Address bits outside [4:2] and the write word are only partly decoded.
   assign w_unused = &{1'b0, address[31:5], address[1:0], data_write};

   assign w_tick      = r_en && (r_pre_cnt == r_prescale);
   assign w_count_inc = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
   // A CPU load of COUNT in a tick cycle suppresses match evaluation.
   assign w_hit       = w_tick && !w_wr_count && (w_count_inc == r_compare);

   // Prescaler: restarts on PRESCALE writes and on CTRL writes with EN=0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre_cnt <= '0;
      end else if (w_wr_pre || (w_wr_ctrl && !data_write[0])) begin
         r_pre_cnt <= '0;
      end else if (r_en) begin
         r_pre_cnt <= w_tick ? '0 : r_pre_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // CTRL: a CPU write overrides the one-shot hardware EN clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en   <= 1'b0;
         r_auto <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en   <= data_write[0];
         r_auto <= data_write[1];
      end else if (w_hit && !r_auto) begin
         r_en   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prescale <= '0;
         r_compare  <= '1;
      end else begin
         if (w_wr_pre) r_prescale <= w_wdata;
         if (w_wr_cmp) r_compare  <= w_wdata;
      end
   end

   // COUNT: a match reloads 0 (auto) or parks at COMPARE (one-shot).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (w_wr_count) begin
         r_count <= w_wdata;
      end else if (w_tick) begin
         if (w_hit) r_count <= r_auto ? '0 : r_compare;
         else       r_count <= w_count_inc;
      end
   end

   // MATCH: set has priority over a same-cycle write-1-to-clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_match <= 1'b0;
      end else if (w_hit) begin
         r_match <= 1'b1;
      end else if (w_wr_status && data_write[0]) begin
         r_match <= 1'b0;
      end
   end

`ifdef TIMER_IRQ_EN
   logic r_irq_en;
   logic r_irq;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_irq_en <= data_write[2];
         r_irq <= r_match & r_irq_en;
      end
   end

   assign w_irq_en_rd = r_irq_en;
   assign irq         = r_irq;
`else
   assign w_irq_en_rd = 1'b0;
   assign irq         = 1'b0;
`endif

   always_comb begin
      data_read = '0;
      case (w_sel)
         A_CTRL:   data_read[2:0]       = {w_irq_en_rd, r_auto, r_en};
         A_PRE:    data_read[WIDTH-1:0] = r_prescale;
         A_CMP:    data_read[WIDTH-1:0] = r_compare;
         A_COUNT:  data_read[WIDTH-1:0] = r_count;
         A_STATUS: data_read[0]         = r_match;
         default:  data_read            = '0;
      endcase
   end

endmodule

// File: tb/tb_driver_timer.sv
// ---------------------------------------------------------------------------
// tb_driver_timer
//   Directed test of driver_timer: a WIDTH=32 instance for the main checks
//   and a WIDTH=8 instance for counter wrap. Expected values are hand
//   computed from the register behaviour, in cycles after the bus write edge.
// ---------------------------------------------------------------------------
module tb_driver_timer;

   logic        clk;
   logic        reset_n;
   logic        cs32;
   logic        cs8;
   logic [31:0] address;
   logic        write_enable;
   logic [31:0] data_write;
   logic [31:0] rd32;
   logic [31:0] rd8;
   logic        irq32;
   logic        irq8;

   int total;
   int bad;

   driver_timer #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .chip_select(cs32), .address(address),
      .write_enable(write_enable), .data_write(data_write),
      .data_read(rd32), .irq(irq32)
   );

   driver_timer #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .chip_select(cs8), .address(address),
      .write_enable(write_enable), .data_write(data_write),
      .data_read(rd8), .irq(irq8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef TIMER_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Bus write; the register updates on the posedge and the task returns
   // 1 time unit after that edge.
   task automatic wr(input bit to8, input logic [2:0] off, input logic [31:0] d);
      @(negedge clk);
      cs32 = !to8;
      cs8 = to8;
      write_enable = 1'b1;
      address = {27'd0, off, 2'b00};
      data_write = d;
      @(posedge clk);
      #1;
      cs32 = 1'b0;
      cs8 = 1'b0;
      write_enable = 1'b0;
   endtask

   task automatic rd(input bit from8, input logic [2:0] off, output logic [31:0] d);
      address = {27'd0, off, 2'b00};
      #1;
      d = from8 ? rd8 : rd32;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reg(input string tag, input bit from8, input logic [2:0] off,
                          input logic [31:0] exp);
      logic [31:0] v;
      rd(from8, off, v);
      chk(tag, v, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      total = 0;
      bad = 0;
      cs32 = 0; cs8 = 0; write_enable = 0; address = '0; data_write = '0;

      // Reset values
      reset_n = 1'b0;
      cyc(3);
      @(negedge clk);
      reset_n = 1'b1;
      chk_reg("rst_ctrl",   0, 3'd0, 32'h0);
      chk_reg("rst_pre",    0, 3'd1, 32'h0);
      chk_reg("rst_cmp",    0, 3'd2, 32'hFFFF_FFFF);
      chk_reg("rst_count",  0, 3'd3, 32'h0);
      chk_reg("rst_status", 0, 3'd4, 32'h0);
      chk_reg("rst_cmp8",   1, 3'd2, 32'h0000_00FF);
      chk("rst_irq", {31'd0, irq32}, 32'h0);

      // Auto-reload: tick every 4 cycles, match 20 cycles after enable
      wr(0, 3'd1, 32'd3);
      wr(0, 3'd2, 32'd5);
      wr(0, 3'd0, 32'h3);
      cyc(19);
      chk_reg("auto_cnt19", 0, 3'd3, 32'd4);
      chk_reg("auto_st19",  0, 3'd4, 32'd0);
      cyc(1);
      chk_reg("auto_st20",  0, 3'd4, 32'd1);
      chk_reg("auto_cnt20", 0, 3'd3, 32'd0);
      wr(0, 3'd4, 32'd1);                   // clear at cycle 21
      chk_reg("auto_w1c",   0, 3'd4, 32'd0);
      cyc(18);
      chk_reg("auto_st39",  0, 3'd4, 32'd0);
      cyc(1);
      chk_reg("auto_st40",  0, 3'd4, 32'd1);
      chk_reg("auto_ctrl",  0, 3'd0, 32'h3);
      wr(0, 3'd4, 32'd1);
      chk_reg("auto_w1c2",  0, 3'd4, 32'd0);
      chk_reg("rsvd5",      0, 3'd5, 32'd0);
      wr(0, 3'd0, 32'h0);

      // One-shot
      wr(0, 3'd3, 32'd0);
      wr(0, 3'd1, 32'd0);
      wr(0, 3'd2, 32'd10);
      wr(0, 3'd0, 32'h1);
      cyc(9);
      chk_reg("os_cnt9",   0, 3'd3, 32'd9);
      chk_reg("os_st9",    0, 3'd4, 32'd0);
      cyc(1);
      chk_reg("os_cnt10",  0, 3'd3, 32'd10);
      chk_reg("os_st10",   0, 3'd4, 32'd1);
      chk_reg("os_ctrl",   0, 3'd0, 32'h0);
      cyc(50);
      chk_reg("os_hold",   0, 3'd3, 32'd10);

      // COUNT write in a tick cycle (PRESCALE=0 ticks every cycle)
      wr(0, 3'd2, 32'd1000);
      wr(0, 3'd0, 32'h1);
      wr(0, 3'd3, 32'd100);
      chk_reg("col_cnt",   0, 3'd3, 32'd100);
      cyc(1);
      chk_reg("col_cnt1",  0, 3'd3, 32'd101);

      // W1C in the same cycle as a match; MATCH is still 1 from the one-shot
      wr(0, 3'd0, 32'h0);
      wr(0, 3'd3, 32'd0);
      wr(0, 3'd2, 32'd3);
      wr(0, 3'd0, 32'h1);                   // edge E0, match at E3
      cyc(2);
      wr(0, 3'd4, 32'd1);                   // lands on E3
      chk_reg("col_st",    0, 3'd4, 32'd1);
      chk_reg("col_cnt3",  0, 3'd3, 32'd3);
      chk_reg("col_ctrl",  0, 3'd0, 32'h0);

      // Wrap on the 8-bit instance
      wr(1, 3'd1, 32'd0);
      wr(1, 3'd2, 32'h02);
      wr(1, 3'd3, 32'h1FE);                 // upper bits dropped
      chk_reg("w8_load",   1, 3'd3, 32'hFE);
      wr(1, 3'd0, 32'h1);
      cyc(1);
      chk_reg("w8_ff",     1, 3'd3, 32'hFF);
      cyc(1);
      chk_reg("w8_00",     1, 3'd3, 32'h00);
      cyc(1);
      chk_reg("w8_01",     1, 3'd3, 32'h01);
      chk_reg("w8_st0",    1, 3'd4, 32'd0);
      cyc(1);
      chk_reg("w8_02",     1, 3'd3, 32'h02);
      chk_reg("w8_st1",    1, 3'd4, 32'd1);
      chk_reg("w8_ctrl",   1, 3'd0, 32'h0);
      chk_reg("w8_iso",    0, 3'd3, 32'd3);  // 32-bit instance untouched

      // Interrupt path
      wr(0, 3'd4, 32'd1);
      wr(0, 3'd3, 32'd0);
      wr(0, 3'd2, 32'd4);
      wr(0, 3'd0, 32'h7);                   // match at E4
      chk_reg("irq_ctrl",  0, 3'd0, IRQ_ON ? 32'h7 : 32'h3);
      cyc(3);
      chk("irq_e3", {31'd0, irq32}, 32'd0);
      cyc(1);
      chk_reg("irq_st4",   0, 3'd4, 32'd1);
      chk("irq_e4", {31'd0, irq32}, 32'd0);
      cyc(1);
      chk("irq_e5", {31'd0, irq32}, {31'd0, IRQ_ON});
      wr(0, 3'd0, 32'h3);
      chk("irq_wr",  {31'd0, irq32}, {31'd0, IRQ_ON});
      cyc(1);
      chk("irq_off", {31'd0, irq32}, 32'd0);
      chk("irq8",    {31'd0, irq8},  32'd0);

      // Reset mid-count returns everything to reset values
      reset_n = 1'b0;
      #2;
      chk_reg("mid_cnt",   0, 3'd3, 32'd0);
      chk_reg("mid_ctrl",  0, 3'd0, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(3);
      chk_reg("post_cnt",  0, 3'd3, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
